// File: rtl/usart_pkg.sv
// +-----------------------------------------------------------------------+
// | usart_pkg : shared constants, FSM encoding and parity helper for USART |
// | Revision  : 1.0                                                       |
// +-----------------------------------------------------------------------+
`default_nettype none

package usart_pkg;

  localparam int PARITY_NONE   = 0;
  localparam int PARITY_ODD    = 1;
  localparam int PARITY_EVEN   = 2;
  localparam int USART_PRESC_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } tx_state_e;

  // Zero-extended data does not change the XOR reduction.
  function automatic logic parity_bit(input logic [8:0] d, input int mode);
    return (mode == PARITY_ODD) ? ~(^d) : (^d);
  endfunction

endpackage

`default_nettype wire

// File: rtl/usart_tx_fifo.sv
// +-----------------------------------------------------------------------+
// | usart_tx_fifo : synchronous FIFO with count, shared by USART TX/RX     |
// | Revision      : 1.0                                                   |
// +-----------------------------------------------------------------------+
`default_nettype none

module usart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             w_push, w_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_q];
  assign w_push   = push && !full;
  assign w_pop    = pop && !empty;

  // Depth is a power of two, so the pointers wrap on natural overflow.
  always_comb begin
    wr_d    = wr_q + PTR_W'(w_push);
    rd_d    = rd_q + PTR_W'(w_pop);
    count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) mem_q[wr_q] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/usart_tx_param.sv
// +-----------------------------------------------------------------------+
// | usart_tx_param : parametrised UART transmitter with TX FIFO            |
// | Revision       : 1.0                                                  |
// +-----------------------------------------------------------------------+
`default_nettype none

module usart_tx_param
  import usart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [USART_PRESC_W-1:0]      prescaler,
  input  logic [DATA_BITS-1:0]          data,
  input  logic                          data_valid,
  output logic                          data_ready,
  output logic                          tx_pin,
  output logic                          uart_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam logic [3:0] c_last_data = 4'(DATA_BITS - 1);
  localparam logic [3:0] c_last_stop = 4'(STOP_BITS - 1);

  tx_state_e                 state_q, state_d;
  logic [USART_PRESC_W-1:0]  baud_q, baud_d, presc_q, presc_d;
  logic [3:0]                bit_q, bit_d;
  logic [DATA_BITS-1:0]      shift_q, shift_d;
  logic                      par_q, par_d, tx_q, tx_d;

  logic                      w_full, w_empty, w_load, w_baud_done;
  logic [DATA_BITS-1:0]      w_head;

  usart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (data_valid),
    .push_data (data),
    .pop       (w_load),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (fifo_count)
  );

  assign w_baud_done = (baud_q == '0);
  assign data_ready  = !w_full;
  assign uart_busy   = (state_q != ST_IDLE) || (fifo_count != '0);
  assign tx_pin      = tx_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    presc_d = presc_q;
    tx_d    = tx_q;
    w_load  = 1'b0;

    if (state_q != ST_IDLE && !w_baud_done) baud_d = baud_q - USART_PRESC_W'(1);

    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        w_load = !w_empty;
      end
      ST_START: if (w_baud_done) begin
        state_d = ST_DATA;
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
        bit_d   = '0;
        baud_d  = presc_q;
      end
      ST_DATA: if (w_baud_done) begin
        baud_d = presc_q;
        if (bit_q == c_last_data) begin
          bit_d = '0;
          if (PARITY != PARITY_NONE) begin
            state_d = ST_PAR;
            tx_d    = par_q;
          end else begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end
        end else begin
          bit_d   = bit_q + 4'd1;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      ST_PAR: if (w_baud_done) begin
        state_d = ST_STOP;
        tx_d    = 1'b1;
        bit_d   = '0;
        baud_d  = presc_q;
      end
      ST_STOP: if (w_baud_done) begin
        if (bit_q == c_last_stop) begin
          // Chain straight into the next start bit when more data is queued.
          if (!w_empty) begin
            w_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          bit_d  = bit_q + 4'd1;
          baud_d = presc_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (w_load) begin
      state_d = ST_START;
      tx_d    = 1'b0;
      shift_d = w_head;
      presc_d = prescaler;
      baud_d  = prescaler;
      bit_d   = '0;
      par_d   = parity_bit(9'(w_head), PARITY);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      presc_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      presc_q <= presc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

endmodule

`default_nettype wire
